// File: rtl/sha_pad_pkg.sv
// Shared constants for the SHA message padder: FSM states, hash-size codes,
// block geometry and the padding marker byte.
package sha_pad_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FILL  = 3'd1;
  localparam logic [2:0] ST_PAD   = 3'd2;
  localparam logic [2:0] ST_LEN   = 3'd3;
  localparam logic [2:0] ST_ISSUE = 3'd4;
  localparam logic [2:0] ST_WAIT  = 3'd5;
  localparam logic [2:0] ST_DONE  = 3'd6;

  localparam logic [1:0] HS_INVALID = 2'b00;
  localparam logic [1:0] HS_256     = 2'b01;
  localparam logic [1:0] HS_384     = 2'b10;
  localparam logic [1:0] HS_512     = 2'b11;

  localparam int unsigned WORDS_256     = 16;
  localparam int unsigned WORDS_512     = 32;
  localparam int unsigned LEN_WORDS_256 = 2;
  localparam int unsigned LEN_WORDS_512 = 4;
  localparam int unsigned IDX_W         = 6;

  localparam logic [7:0] PAD_BYTE = 8'h80;

  function automatic logic [IDX_W-1:0] words_per_block(input logic [1:0] hs);
    return (hs == HS_256) ? IDX_W'(WORDS_256) : IDX_W'(WORDS_512);
  endfunction

  function automatic logic [IDX_W-1:0] len_words(input logic [1:0] hs);
    return (hs == HS_256) ? IDX_W'(LEN_WORDS_256) : IDX_W'(LEN_WORDS_512);
  endfunction

endpackage

// File: rtl/sha_pad_last_word.sv
// Combinational merge of the final message word with the 0x80 marker.
// A full final word cannot hold the marker, so spill_o asks for a 0x80000000 word next.
module sha_pad_last_word
  import sha_pad_pkg::*;
(
  input  logic [31:0] data_i,
  input  logic [2:0]  bytes_i,
  output logic [31:0] word_o,
  output logic        spill_o,
  output logic [2:0]  bytes_o
);

  // Counts above 4 are clamped to a full word.
  always_comb begin
    word_o  = 32'h0;
    spill_o = 1'b0;
    bytes_o = bytes_i;
    case (bytes_i)
      3'd0: word_o = {PAD_BYTE, 24'h0};
      3'd1: word_o = {data_i[31:24], PAD_BYTE, 16'h0};
      3'd2: word_o = {data_i[31:16], PAD_BYTE, 8'h0};
      3'd3: word_o = {data_i[31:8], PAD_BYTE};
      default: begin
        word_o  = data_i;
        spill_o = 1'b1;
        bytes_o = 3'd4;
      end
    endcase
  end

endmodule

// File: rtl/sha_msg_padder.sv
// SHA-256/384/512 message padder: packs a word stream into padded blocks and
// handshakes them one at a time to the hash unit. SHA_PAD_ERR_EN adds pad_err.
module sha_msg_padder
  import sha_pad_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    hash_size,
  input  logic          msg_start,
  input  logic          data_valid,
  output logic          data_ready,
  input  logic [31:0]   data_in,
  input  logic          data_last,
  input  logic [2:0]    data_bytes,
  output logic          sha_start,
  output logic          sha_input_valid,
  output logic [1023:0] sha_win,
  output logic [1:0]    sha_hash_size,
  input  logic          sha_output_valid,
  output logic          busy,
  output logic          msg_done
`ifdef SHA_PAD_ERR_EN
  ,
  output logic          pad_err
`endif
);

  logic [2:0]        state_q, state_d;
  logic [1:0]        hs_q, hs_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_nx;
  logic [IDX_W-1:0]  idx_q, idx_d, idx_nx;
  logic [31:0][31:0] win_q, win_d;
  logic              first_q, first_d;
  logic              final_q, final_d;
  logic              extra_q, extra_d;
  logic              spill_q, spill_d;
  logic              start_q, start_d;
  logic              ivalid_q, ivalid_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic              ready_q, ready_d;

  logic [31:0]       lw_word;
  logic              lw_spill;
  logic [2:0]        lw_bytes;
  logic [2:0]        add_bytes;
  logic [IDX_W-1:0]  wpb, wlen;
  logic [4:0]        wpos;
  logic [63:0]       bit_len;
  logic              is256;
  logic              fire;

  sha_pad_last_word u_last_word (
    .data_i  (data_in),
    .bytes_i (data_bytes),
    .word_o  (lw_word),
    .spill_o (lw_spill),
    .bytes_o (lw_bytes)
  );

  // Word i of a block lives in the packed slot 15-i (SHA-256) or 31-i.
  assign is256     = (hs_q == HS_256);
  assign wpb       = words_per_block(hs_q);
  assign wlen      = len_words(hs_q);
  assign idx_nx    = idx_q + IDX_W'(1);
  assign wpos      = is256 ? 5'(IDX_W'(15) - idx_q) : 5'(IDX_W'(31) - idx_q);
  assign add_bytes = data_last ? lw_bytes : 3'd4;
  assign cnt_nx    = cnt_q + CNT_W'(add_bytes);
  assign bit_len   = 64'(cnt_q) << 3;
  assign fire      = (state_q == ST_FILL) && data_valid;

  always_comb begin
    state_d = state_q;
    hs_d    = hs_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    win_d   = win_q;
    first_d = first_q;
    final_d = final_q;
    extra_d = extra_q;
    spill_d = spill_q;
    case (state_q)
      ST_IDLE: begin
        if (msg_start && (hash_size != HS_INVALID)) begin
          hs_d    = hash_size;
          cnt_d   = '0;
          idx_d   = '0;
          win_d   = '0;
          first_d = 1'b1;
          final_d = 1'b0;
          extra_d = 1'b0;
          spill_d = 1'b0;
          state_d = ST_FILL;
        end
      end
      ST_FILL: begin
        if (fire) begin
          cnt_d = cnt_nx;
          idx_d = idx_nx;
          if (data_last) begin
            win_d[wpos] = lw_word;
            spill_d     = lw_spill;
            if (idx_nx == wpb) begin
              extra_d = 1'b1;
              state_d = ST_ISSUE;
            end else if (!lw_spill && (idx_nx == wpb - wlen)) begin
              state_d = ST_LEN;
            end else begin
              state_d = ST_PAD;
            end
          end else begin
            win_d[wpos] = data_in;
            if (idx_nx == wpb) state_d = ST_ISSUE;
          end
        end
      end
      // A pending spill word goes first; the length slot is reachable only
      // if we land exactly on it, otherwise fill to the end and add a block.
      ST_PAD: begin
        win_d[wpos] = spill_q ? {PAD_BYTE, 24'h0} : 32'h0;
        spill_d     = 1'b0;
        idx_d       = idx_nx;
        if (idx_nx == wpb) begin
          extra_d = 1'b1;
          state_d = ST_ISSUE;
        end else if (idx_nx == wpb - wlen) begin
          state_d = ST_LEN;
        end
      end
      ST_LEN: begin
        if (!is256) begin
          win_d[3] = 32'h0;
          win_d[2] = 32'h0;
        end
        win_d[1] = bit_len[63:32];
        win_d[0] = bit_len[31:0];
        final_d  = 1'b1;
        state_d  = ST_ISSUE;
      end
      ST_ISSUE: begin
        first_d = 1'b0;
        idx_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (sha_output_valid) begin
          if (final_q) begin
            state_d = ST_DONE;
          end else if (extra_q) begin
            extra_d = 1'b0;
            state_d = ST_PAD;
          end else begin
            state_d = ST_FILL;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    start_d  = (state_d == ST_ISSUE) && first_q;
    ivalid_d = (state_d == ST_ISSUE);
    done_d   = (state_d == ST_DONE);
    busy_d   = (state_d != ST_IDLE) && (state_d != ST_DONE);
    ready_d  = (state_d == ST_FILL);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      hs_q     <= HS_INVALID;
      cnt_q    <= '0;
      idx_q    <= '0;
      win_q    <= '0;
      first_q  <= 1'b0;
      final_q  <= 1'b0;
      extra_q  <= 1'b0;
      spill_q  <= 1'b0;
      start_q  <= 1'b0;
      ivalid_q <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      hs_q     <= hs_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      win_q    <= win_d;
      first_q  <= first_d;
      final_q  <= final_d;
      extra_q  <= extra_d;
      spill_q  <= spill_d;
      start_q  <= start_d;
      ivalid_q <= ivalid_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      ready_q  <= ready_d;
    end
  end

  assign data_ready      = ready_q;
  assign sha_start       = start_q;
  assign sha_input_valid = ivalid_q;
  assign sha_win         = win_q;
  assign sha_hash_size   = hs_q;
  assign busy            = busy_q;
  assign msg_done        = done_q;

`ifdef SHA_PAD_ERR_EN
  logic err_q, err_d;

  // Sticky until the next accepted start; a wrapped count is detected by the sum going backwards.
  always_comb begin
    err_d = err_q;
    if ((state_q == ST_IDLE) && msg_start) begin
      err_d = (hash_size == HS_INVALID) ? 1'b1 : 1'b0;
      if (hash_size == HS_INVALID) err_d = 1'b1;
    end else if (fire && ((cnt_nx < cnt_q) || (data_last && (data_bytes > 3'd4)))) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err_q <= 1'b0;
    else      err_q <= err_d;
  end

  assign pad_err = err_q;
`endif

endmodule
